// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of the single-ported fast_memory: CPU has fixed priority,
// DMA wins after MAX_WAIT consecutive lost arbitrations. Grant, bus drive and read return are registered.
//
// state   | meaning
// IDLE    | no access on the memory bus this cycle
// ACC_CPU | captured CPU access is on the memory bus
// ACC_DMA | captured DMA access is on the memory bus
module memory_arbiter #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 15,
  parameter int          MAX_WAIT = 4,
  parameter int unsigned RO_BASE  = 'h6000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {IDLE, ACC_CPU, ACC_DMA} state_t;

  localparam logic [3:0]        MAX_W  = 4'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] RO_LIM = ADDR_W'(RO_BASE);

  state_t              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic                we_q, we_d;
  logic                cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d;
  logic                cpu_rvalid_q, cpu_rvalid_d, dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_in_q, mem_in_d;
  logic                mem_load_q, mem_load_d;

  logic                cpu_wins, dma_wins, any_win, sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    cpu_wins  = cpu_req && !(dma_req && (wait_q == MAX_W));
    dma_wins  = dma_req && !cpu_wins;
    any_win   = cpu_wins || dma_wins;
    sel_we    = cpu_wins ? cpu_we    : dma_we;
    sel_addr  = cpu_wins ? cpu_addr  : dma_addr;
    sel_wdata = cpu_wins ? cpu_wdata : dma_wdata;

    state_d   = cpu_wins ? ACC_CPU : (dma_wins ? ACC_DMA : IDLE);
    cpu_gnt_d = cpu_wins;
    dma_gnt_d = dma_wins;

    // Writes into the read-only region are granted but never reach the memory.
    mem_load_d    = any_win && sel_we && (sel_addr < RO_LIM);
    mem_address_d = any_win ? sel_addr  : mem_address_q;
    mem_in_d      = any_win ? sel_wdata : mem_in_q;
    we_d          = any_win ? sel_we    : we_q;

    if (cpu_req && dma_req && cpu_wins)
      wait_d = (wait_q == MAX_W) ? wait_q : wait_q + 4'd1;
    else
      wait_d = 4'd0;

    cpu_rvalid_d = (state_q == ACC_CPU) && !we_q;
    dma_rvalid_d = (state_q == ACC_DMA) && !we_q;
    cpu_rdata_d  = cpu_rvalid_d ? mem_out : cpu_rdata_q;
    dma_rdata_d  = dma_rvalid_d ? mem_out : dma_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_q        <= 4'd0;
      we_q          <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      dma_gnt_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
      mem_load_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      we_q          <= we_d;
      cpu_gnt_q     <= cpu_gnt_d;
      dma_gnt_q     <= dma_gnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      dma_rvalid_q  <= dma_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
      mem_address_q <= mem_address_d;
      mem_in_q      <= mem_in_d;
      mem_load_q    <= mem_load_d;
    end
  end

  assign cpu_gnt     = cpu_gnt_q;
  assign dma_gnt     = dma_gnt_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign dma_rvalid  = dma_rvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign dma_rdata   = dma_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_in      = mem_in_q;
  assign mem_load    = mem_load_q;

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single fast_memory port (16-bit data, 15-bit address, write on load at clock edge, combinational read) between two requesters: the CPU data port (high priority) and a screen/DMA engine (low priority).
- Fixed priority with a starvation guard.
- One memory access per cycle sustained; registered grant, registered memory drive, registered read return.
- Sits between the CPU/DMA blocks and fast_memory in the top level.

Parameters:
- DATA_W, 16, data width of memory and requester data buses
- ADDR_W, 15, address width
- MAX_WAIT, 4, consecutive lost arbitrations after which DMA wins over CPU (range 1..15)
- RO_BASE, 'h6000, first read-only address (keyboard); writes at or above are dropped

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write enable (1 = write, 0 = read)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU access is on the memory bus this cycle
- cpu_rdata  out  DATA_W  CPU read data
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rdata, dma_rvalid: same as CPU set, DMA side
- mem_address  out  ADDR_W  to fast_memory address
- mem_in  out  DATA_W  to fast_memory in
- mem_load  out  1  to fast_memory load
- mem_out  in  DATA_W  from fast_memory out

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset: state IDLE; cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_load = 0; mem_address, mem_in, cpu_rdata, dma_rdata = 0; wait counter = 0.
- States: IDLE (bus idle), ACC_CPU, ACC_DMA. State changes only at rising edges.
- Decision, taken at every edge in every state: sample cpu_req and dma_req.
  - Neither high -> IDLE.
  - Only one high -> that requester.
  - Both high -> CPU, unless wait counter == MAX_WAIT, then DMA.
  - Winner's we/addr/wdata are captured into mem_load/mem_address/mem_in; next state is ACC_x.
- ACC_x cycle: x_gnt = 1, the memory bus is driven with the captured access, and mem_load = captured we.
- At the end of ACC_x:
  - Read: mem_out is registered into x_rdata and x_rvalid = 1 for the following cycle.
  - Write: x_rvalid stays 0 and x_rdata holds its value.
- Latency: req high in cycle N -> gnt in cycle N+1 -> rvalid and rdata in cycle N+2 (reads).
- Throughput: back-to-back accesses have no bubble. ACC cycles may follow each other directly, alternating or repeating requesters.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - req still high in the gnt cycle counts as a new request for the next access.
  - For a single access, drop req in the gnt cycle.
- Wait counter:
  - Increments when both requests are high and CPU wins.
  - Clears when DMA is granted or dma_req is low at a decision.
  - Saturates at MAX_WAIT.
- Read-only region: a write whose captured address is >= RO_BASE still gets gnt, but mem_load stays 0. The write is silently dropped. Reads there pass through normally.
- When neither ACC is active, mem_load = 0. mem_address and mem_in hold their last values.
- Reset during an ACC cycle:
  - That cycle's bus drive and mem_load remain as registered, so the memory write at that edge completes. Memory itself is not reset.
  - All outputs clear at the edge and no rvalid follows.
  - Requests pending at that edge are discarded.
- The gnt and rvalid pulses of the two ports may overlap in one cycle (read from the previous access alongside the new grant). cpu_gnt and dma_gnt are never both high.

Test Plan:
- Reset then idle: hold reset 2 cycles -> all outputs 0; with no req for 5 cycles -> mem_load = 0, no gnt.
- CPU write then read: cpu write 'hABAB to 'h0000, then read 'h0000 -> cpu_gnt in cycle N+1, mem_load = 1 once; read gives cpu_rvalid with cpu_rdata = 'hABAB at N+2 after the read req.
- Read-only drop: cpu write 'hCDCD to 'h6000 -> cpu_gnt pulses, mem_load stays 0; DMA write 'hABAB to 'h6001 -> dropped the same way.
- Priority and starvation: cpu_req and dma_req held high continuously, MAX_WAIT = 4 -> grant sequence CPU,CPU,CPU,CPU,DMA,CPU,CPU,CPU,CPU,DMA, with no idle cycles between grants.
- Back-to-back DMA reads of 'h0000..'h0003 (preloaded 1,2,3,4) -> dma_gnt high 4 consecutive cycles; dma_rvalid 4 consecutive cycles with dma_rdata 1,2,3,4.
- Reset mid-access: assert reset during an ACC_CPU write of 'h1234 to 'h0010 -> memory 'h0010 = 'h1234 afterwards; cpu_rvalid never pulses; state IDLE and wait counter 0 after reset.
